// File: rtl/ifetch_buffer_pkg.sv
// ifetch_buffer_pkg: shared fetch constants and queue entry type
package ifetch_buffer_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int DEPTH_DEF = 2;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;
endpackage

// File: rtl/ifetch_buffer_if.sv
// ifetch_buffer_if: instruction-memory read bus between fetch and memory
interface ifetch_buffer_if;
  logic req;
  logic [31:0] addr;
  logic valid;
  logic [31:0] rdata;
  modport master(output req, addr, input valid, rdata);
  modport slave(input req, addr, output valid, rdata);
endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: small circular queue of fetched {instr, pc} entries with sync clear
module ifetch_fifo
  import ifetch_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  entry_t din,
  output entry_t dout,
  output logic full,
  output logic empty,
  output logic [CW-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  // pointers and occupancy; clear drops every entry at once
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= inc(wp);
      if (pop) rp <= inc(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // storage needs no reset; occupancy decides what is live
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end
  assign dout = mem[rp];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: decoupled fetch with a small instruction queue feeding decode
module ifetch_buffer
  import ifetch_buffer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic stallD,
  input  logic PCsrcE,
  input  logic [31:0] PCplusImmE,
  ifetch_buffer_if.master imem,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic validD
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0] pcF, req_pc;
  logic inflight, push, pop, full, empty;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  entry_t head;
  // a request is only issued when its response is guaranteed a queue slot
  always_comb begin
    pop = !PCsrcE && !stallD && !empty;
    push = imem.valid && inflight && !PCsrcE && (!full || pop);
    occ = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    imem.req = !rst && !PCsrcE && occ < (CW+1)'(DEPTH);
    imem.addr = pcF;
  end
  ifetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(PCsrcE),
    .push(push),
    .pop(pop),
    .din(entry_t'{instr: imem.rdata, pc: req_pc}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // fetch PC and in-flight tracking; a redirect squashes the outstanding response
  always_ff @(posedge clk) begin
    if (rst) begin
      pcF <= RESET_PC;
      req_pc <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem.req;
      if (PCsrcE) pcF <= {PCplusImmE[31:2], 2'b00};
      else if (imem.req) begin
        pcF <= pcF + 32'd4;
        req_pc <= pcF;
      end
    end
  end
  // decode-facing registers: redirect beats stall, empty queue yields a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      instrD <= NOP;
      PCD <= '0;
      validD <= 1'b0;
    end else if (PCsrcE) begin
      instrD <= NOP;
      validD <= 1'b0;
    end else if (!stallD) begin
      instrD <= empty ? NOP : head.instr;
      PCD <= empty ? PCD : head.pc;
      validD <= !empty;
    end
  end
endmodule

// File: doc/ifetch_buffer.md
IFETCH_BUFFER -- requirements
Module: ifetch_buffer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, the instruction queue capacity in entries; only 2 is required.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stallD  input  1  decode stall from the hazard unit; holds the decode-facing outputs.
REQ-006 SHALL have port PCsrcE  input  1  taken-branch/jump redirect from execute.
REQ-007 SHALL have port PCplusImmE  input  32  redirect target.
REQ-008 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-009 SHALL have port imem_addr  output  32  read address, valid while imem_req=1.
REQ-010 SHALL have port imem_valid  input  1  read data valid, exactly 1 cycle after the accepted request.
REQ-011 SHALL have port imem_rdata  input  32  instruction word.
REQ-012 SHALL have port instrD  output  32  instruction to decode.
REQ-013 SHALL have port PCD  output  32  PC of instrD.
REQ-014 SHALL have port validD  output  1  instrD is a real instruction; 0 means bubble.

Function
REQ-015 SHALL hold fetch PC register pcF; imem_addr=pcF; each issued request advances pcF by 4, mod 2^32 (32'hFFFFFFFC wraps to 0).
REQ-016 SHALL assert imem_req when rst=0, PCsrcE=0 and (count + inflight - pop) < DEPTH, where inflight=1 if a request was issued last cycle and not squashed, and pop=1 if the queue is popped this cycle.
REQ-017 SHALL push {imem_rdata, request PC} into the queue when imem_valid=1 and the response is not squashed.
REQ-018 SHALL allow push and pop in the same cycle, including when count=DEPTH.
REQ-019 SHALL, when stallD=0, load instrD/PCD from the queue head with validD=1 and pop, or load instrD=NOP (32'h00000013) with validD=0 when the queue is empty (no same-cycle bypass from imem_rdata).
REQ-020 SHALL hold instrD/PCD/validD and not pop when stallD=1.
REQ-021 SHALL, on PCsrcE=1: set pcF to {PCplusImmE[31:2],2'b00}, clear the queue, squash any in-flight response, deassert imem_req that cycle, and load instrD=NOP, validD=0 next edge.
REQ-022 SHALL give PCsrcE priority over stallD and over a simultaneous imem_valid push.
REQ-023 SHALL reach first validD=1 three edges after rst deasserts (issue, push, load) when stallD=0.
REQ-024 SHALL sustain one instruction per cycle when stallD=0 and no redirect occurs.

Reset
REQ-025 SHALL, on rising clk with rst=1, set pcF=RESET_PC, count=0, inflight=0, instrD=32'h00000013, PCD=0 and validD=0.
REQ-026 SHALL keep imem_req=0 during rst.
REQ-027 SHALL discard any response arriving in the cycle after reset.
REQ-028 SHALL abandon a mid-operation fetch on reset, with no stale entry surviving.

Structure
REQ-029 SHALL take RESET_PC, NOP encoding (32'h00000013) and DEPTH from the shared processor constants header/package.
REQ-030 SHALL implement the queue as one sub-module ifetch_fifo: 64-bit entries, synchronous clear, push/pop/full/empty.
REQ-031 SHALL be instantiated ahead of the decode stage, replacing the direct fetch-to-decode path.

Verification
REQ-032 SHALL pass reset-then-run: memory returns addr-as-data, stallD=0 -> validD=1 from the 3rd edge; PCD 0,4,8,... each cycle; instrD=PCD.
REQ-033 SHALL pass stall: stallD=1 for 4 cycles while PCD=8 -> PCD/instrD hold 8; imem_req drops once count=2; on release PCD 12,16 with no gap or duplicate.
REQ-034 SHALL pass redirect: PCsrcE=1, PCplusImmE=32'h00000103 with an in-flight response -> next validD=0; pcF=32'h100; squashed response never appears; next valid PCD=32'h100.
REQ-035 SHALL pass redirect during stall: stallD=1 and PCsrcE=1 together -> validD=0 next edge; no PC from before the redirect is delivered afterwards.
REQ-036 SHALL pass wrap: RESET_PC=32'hFFFFFFF8 -> PCD sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-037 SHALL pass mid-run reset: rst=1 for 1 cycle while queue full -> instrD=NOP, validD=0; restart at RESET_PC with no stale entries.
